// File: rtl/branch_target_pred_pkg.sv
// Shared constants for the branch target predictor: 2-bit direction counter
// encoding, instruction size and the counter value given to fresh entries.
package branch_target_pred_pkg;

  localparam logic [1:0] CNT_SNT = 2'b00;
  localparam logic [1:0] CNT_WNT = 2'b01;
  localparam logic [1:0] CNT_WT  = 2'b10;
  localparam logic [1:0] CNT_ST  = 2'b11;

  localparam int INSTR_BYTES = 4;

  localparam logic [1:0] CNT_INIT_ALLOC = CNT_WT;

  // The MSB of the counter is the taken/not-taken prediction.
  function automatic logic cnt_predicts_taken(input logic [1:0] cnt);
    return cnt[1];
  endfunction

endpackage

// File: rtl/branch_target_pred_sat_counter_2b.sv
// Combinational next state of a 2-bit saturating direction counter:
// count up on taken, down on not taken, clamped to 00..11.
module sat_counter_2b
  import branch_target_pred_pkg::*;
(
  input  logic [1:0] i_cnt,
  input  logic       i_taken,
  output logic [1:0] o_cnt
);

  always_comb begin
    // NOTE: default assignment first so every path drives o_cnt and no latch is inferred.
    o_cnt = i_cnt;
    if (i_taken) begin
      if (i_cnt != CNT_ST) o_cnt = i_cnt + 2'd1;
    end else begin
      if (i_cnt != CNT_SNT) o_cnt = i_cnt - 2'd1;
    end
  end

endmodule

// File: rtl/branch_target_pred.sv
// Direct-mapped branch target buffer with 2-bit direction counters. IF lookups
// return a registered prediction one cycle later; EX updates train the table.
module branch_target_pred
  import branch_target_pred_pkg::*;
#(
  parameter int WIDTH_I = 32,
  parameter int DEPTH   = 16,
  parameter int SHIFT   = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               lkp_en,
  input  logic [WIDTH_I-1:0] lkp_pc,
  output logic               pred_valid,
  output logic               pred_taken,
  output logic [WIDTH_I-1:0] pred_target,
  input  logic               upd_en,
  input  logic [WIDTH_I-1:0] upd_pc,
  input  logic [WIDTH_I-1:0] upd_pc_next,
  input  logic [WIDTH_I-1:0] upd_imme,
  input  logic               upd_taken,
  output logic               tgt_valid,
  output logic [WIDTH_I-1:0] tgt_out
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int TAG_W = WIDTH_I - IDX_W - 2;

  logic [DEPTH-1:0] r_valid;
  logic [1:0]       r_cnt    [DEPTH];
  logic [TAG_W-1:0] r_tag    [DEPTH];
  logic [WIDTH_I-1:0] r_target [DEPTH];

  logic [IDX_W-1:0]   w_lkp_idx;
  logic [TAG_W-1:0]   w_lkp_tag;
  logic               w_lkp_hit;
  logic [IDX_W-1:0]   w_upd_idx;
  logic [TAG_W-1:0]   w_upd_tag;
  logic               w_upd_hit;
  logic [WIDTH_I-1:0] w_upd_target;
  logic [1:0]         w_cnt_next;
  logic               w_unused_pc_lsbs;

  assign w_lkp_idx = lkp_pc[IDX_W+1:2];
  assign w_lkp_tag = lkp_pc[WIDTH_I-1:IDX_W+2];
  assign w_lkp_hit = r_valid[w_lkp_idx] && (r_tag[w_lkp_idx] == w_lkp_tag);

  assign w_upd_idx = upd_pc[IDX_W+1:2];
  assign w_upd_tag = upd_pc[WIDTH_I-1:IDX_W+2];
  assign w_upd_hit = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);

  // Byte alignment bits of the branch PC never select an entry.
  assign w_unused_pc_lsbs = ^upd_pc[1:0];

  // Wraps modulo 2^WIDTH_I; negative immediates arrive sign-extended.
  assign w_upd_target = upd_pc_next + (upd_imme << SHIFT);

  sat_counter_2b u_sat_counter (
    .i_cnt   (r_cnt[w_upd_idx]),
    .i_taken (upd_taken),
    .o_cnt   (w_cnt_next)
  );

  // NOTE: the table is reset explicitly so a mid-stream reset leaves no stale entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_cnt[i]    <= CNT_WNT;
        r_tag[i]    <= '0;
        r_target[i] <= '0;
      end
    end else if (flush) begin
      r_valid <= '0;
    end else if (upd_en) begin
      if (w_upd_hit) begin
        r_cnt[w_upd_idx]    <= w_cnt_next;
        r_target[w_upd_idx] <= w_upd_target;
      end else if (upd_taken) begin
        r_valid[w_upd_idx]  <= 1'b1;
        r_tag[w_upd_idx]    <= w_upd_tag;
        r_target[w_upd_idx] <= w_upd_target;
        r_cnt[w_upd_idx]    <= CNT_INIT_ALLOC;
      end
    end
  end

  // Lookup reads the table before this edge's update lands: no bypass path.
  // NOTE: non-blocking assignments keep every register sampling pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pred_valid  <= 1'b0;
      pred_taken  <= 1'b0;
      pred_target <= '0;
    end else begin
      pred_valid <= lkp_en & ~flush;
      if (lkp_en) begin
        pred_taken  <= w_lkp_hit & cnt_predicts_taken(r_cnt[w_lkp_idx]);
        pred_target <= w_lkp_hit ? r_target[w_lkp_idx]
                                 : lkp_pc + WIDTH_I'(INSTR_BYTES);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tgt_valid <= 1'b0;
      tgt_out   <= '0;
    end else begin
      tgt_valid <= upd_en;
      if (upd_en) tgt_out <= w_upd_target;
    end
  end

endmodule

// File: tb/tb_branch_target_pred.sv
// Self-checking bench for branch_target_pred: directed vector table, reset
// corner sequences and randomized traffic against a behavioural table model.
module tb_branch_target_pred;

  localparam int W     = 32;
  localparam int DEPTH = 16;

  logic         clk;
  logic         rst_n;
  logic         flush;
  logic         lkp_en;
  logic [W-1:0] lkp_pc;
  logic         pred_valid;
  logic         pred_taken;
  logic [W-1:0] pred_target;
  logic         upd_en;
  logic [W-1:0] upd_pc;
  logic [W-1:0] upd_pc_next;
  logic [W-1:0] upd_imme;
  logic         upd_taken;
  logic         tgt_valid;
  logic [W-1:0] tgt_out;

  branch_target_pred #(.WIDTH_I(W), .DEPTH(DEPTH), .SHIFT(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .lkp_en      (lkp_en),
    .lkp_pc      (lkp_pc),
    .pred_valid  (pred_valid),
    .pred_taken  (pred_taken),
    .pred_target (pred_target),
    .upd_en      (upd_en),
    .upd_pc      (upd_pc),
    .upd_pc_next (upd_pc_next),
    .upd_imme    (upd_imme),
    .upd_taken   (upd_taken),
    .tgt_valid   (tgt_valid),
    .tgt_out     (tgt_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
  endtask

  task automatic check_outputs(input string nm, input logic pv, input logic pt,
                               input logic [W-1:0] ptgt, input logic tv,
                               input logic [W-1:0] tout);
    check({nm, ".pred_valid"},  {31'd0, pred_valid}, {31'd0, pv});
    check({nm, ".pred_taken"},  {31'd0, pred_taken}, {31'd0, pt});
    check({nm, ".pred_target"}, pred_target, ptgt);
    check({nm, ".tgt_valid"},   {31'd0, tgt_valid}, {31'd0, tv});
    check({nm, ".tgt_out"},     tgt_out, tout);
  endtask

  task automatic drive(input logic le, input logic [W-1:0] lp, input logic ue,
                       input logic [W-1:0] up, input logic [W-1:0] pn,
                       input logic [W-1:0] im, input logic ut, input logic fl);
    lkp_en = le; lkp_pc = lp; upd_en = ue; upd_pc = up;
    upd_pc_next = pn; upd_imme = im; upd_taken = ut; flush = fl;
  endtask

  task automatic idle();
    drive(1'b0, '0, 1'b0, '0, '0, '0, 1'b0, 1'b0);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    string        name;
    logic         le;
    logic [W-1:0] lp;
    logic         ue;
    logic [W-1:0] up, pn, im;
    logic         ut, fl;
    logic         e_pv, e_pt;
    logic [W-1:0] e_ptgt;
    logic         e_tv;
    logic [W-1:0] e_tout;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string nm, logic le, logic [W-1:0] lp, logic ue,
                              logic [W-1:0] up, logic [W-1:0] pn, logic [W-1:0] im,
                              logic ut, logic fl, logic pv, logic pt,
                              logic [W-1:0] ptgt, logic tv, logic [W-1:0] tout);
    vec_t v;
    v.name = nm; v.le = le; v.lp = lp; v.ue = ue; v.up = up; v.pn = pn; v.im = im;
    v.ut = ut; v.fl = fl; v.e_pv = pv; v.e_pt = pt; v.e_ptgt = ptgt; v.e_tv = tv;
    v.e_tout = tout;
    return v;
  endfunction

  task automatic fill_table();
    //                 name          le lkp_pc ue upd_pc  pc_next     imme        ut fl  pv pt target   tv tgt_out
    vecs.push_back(mk("cold_lookup", 1, 32'h40, 0, 32'h0,   32'h0,       32'h0,       0, 0, 1, 0, 32'h44,  0, 32'h0));
    vecs.push_back(mk("alloc_100",   0, 32'h0,  1, 32'h100, 32'h104,     32'h10,      1, 0, 0, 0, 32'h44,  1, 32'h144));
    vecs.push_back(mk("hit_100",     1, 32'h100,0, 32'h0,   32'h0,       32'h0,       0, 0, 1, 1, 32'h144, 0, 32'h144));
    vecs.push_back(mk("neg_imme",    0, 32'h0,  1, 32'h500, 32'h104,     32'hFFFFFFFC,0, 0, 0, 1, 32'h144, 1, 32'hF4));
    vecs.push_back(mk("wrap_imme",   0, 32'h0,  1, 32'h600, 32'hFFFFFFFC,32'h1,       0, 0, 0, 1, 32'h144, 1, 32'h0));
    vecs.push_back(mk("nt_1",        0, 32'h0,  1, 32'h100, 32'h104,     32'h10,      0, 0, 0, 1, 32'h144, 1, 32'h144));
    vecs.push_back(mk("nt_2",        0, 32'h0,  1, 32'h100, 32'h104,     32'h10,      0, 0, 0, 1, 32'h144, 1, 32'h144));
    vecs.push_back(mk("snt_lookup",  1, 32'h100,0, 32'h0,   32'h0,       32'h0,       0, 0, 1, 0, 32'h144, 0, 32'h144));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk("t_walk",    0, 32'h0,  1, 32'h100, 32'h104,     32'h10,      1, 0, 0, 0, 32'h144, 1, 32'h144));
    vecs.push_back(mk("st_lookup",   1, 32'h100,0, 32'h0,   32'h0,       32'h0,       0, 0, 1, 1, 32'h144, 0, 32'h144));
    vecs.push_back(mk("alias_miss",  1, 32'h140,0, 32'h0,   32'h0,       32'h0,       0, 0, 1, 0, 32'h144, 0, 32'h144));
    vecs.push_back(mk("alias_alloc", 0, 32'h0,  1, 32'h140, 32'h144,     32'h20,      1, 0, 0, 0, 32'h144, 1, 32'h1C4));
    vecs.push_back(mk("evicted_100", 1, 32'h100,0, 32'h0,   32'h0,       32'h0,       0, 0, 1, 0, 32'h104, 0, 32'h1C4));
    vecs.push_back(mk("hit_140",     1, 32'h140,0, 32'h0,   32'h0,       32'h0,       0, 0, 1, 1, 32'h1C4, 0, 32'h1C4));
    vecs.push_back(mk("rbw_same",    1, 32'h140,1, 32'h140, 32'h144,     32'h40,      0, 0, 1, 1, 32'h1C4, 1, 32'h244));
    vecs.push_back(mk("rbw_after",   1, 32'h140,0, 32'h0,   32'h0,       32'h0,       0, 0, 1, 0, 32'h244, 0, 32'h244));
    vecs.push_back(mk("flush_upd",   1, 32'h140,1, 32'h200, 32'h204,     32'h4,       1, 1, 0, 0, 32'h244, 1, 32'h214));
    vecs.push_back(mk("post_fl_200", 1, 32'h200,0, 32'h0,   32'h0,       32'h0,       0, 0, 1, 0, 32'h204, 0, 32'h214));
    vecs.push_back(mk("post_fl_140", 1, 32'h140,0, 32'h0,   32'h0,       32'h0,       0, 0, 1, 0, 32'h144, 0, 32'h214));
  endtask

  // ---------------- behavioural reference model ----------------
  bit           m_valid [DEPTH];
  int           m_cnt   [DEPTH];
  int unsigned  m_tag   [DEPTH];
  logic [W-1:0] m_tgt   [DEPTH];
  logic         m_pv, m_pt, m_tv;
  logic [W-1:0] m_ptgt, m_tout;

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_valid[i] = 0; m_cnt[i] = 1; m_tag[i] = 0; m_tgt[i] = '0;
    end
    m_pv = 0; m_pt = 0; m_tv = 0; m_ptgt = '0; m_tout = '0;
  endtask

  task automatic model_step(input logic le, input logic [W-1:0] lp, input logic ue,
                            input logic [W-1:0] up, input logic [W-1:0] pn,
                            input logic [W-1:0] im, input logic ut, input logic fl);
    int          li, ui;
    int unsigned lt, ut_tag;
    bit          lhit, uhit;
    logic [W-1:0] target;
    li = int'((lp / 4) % DEPTH);  lt = lp / (4 * DEPTH);
    ui = int'((up / 4) % DEPTH);  ut_tag = up / (4 * DEPTH);
    lhit = m_valid[li] && (m_tag[li] == lt);
    uhit = m_valid[ui] && (m_tag[ui] == ut_tag);
    target = pn + im * 4;
    m_pv = le && !fl;
    if (le) begin
      m_pt   = lhit && (m_cnt[li] >= 2);
      m_ptgt = lhit ? m_tgt[li] : lp + 4;
    end
    m_tv = ue;
    if (ue) m_tout = target;
    if (fl) begin
      for (int i = 0; i < DEPTH; i++) m_valid[i] = 0;
    end else if (ue) begin
      if (uhit) begin
        m_cnt[ui] = ut ? ((m_cnt[ui] == 3) ? 3 : m_cnt[ui] + 1)
                       : ((m_cnt[ui] == 0) ? 0 : m_cnt[ui] - 1);
        m_tgt[ui] = target;
      end else if (ut) begin
        m_valid[ui] = 1; m_tag[ui] = ut_tag; m_tgt[ui] = target; m_cnt[ui] = 2;
      end
    end
  endtask

  function automatic logic [W-1:0] rand_pc();
    return (W'($urandom_range(0, 2)) << 6) | (W'($urandom_range(0, DEPTH - 1)) << 2)
           | W'($urandom_range(0, 3));
  endfunction

  task automatic apply_reset();
    idle();
    rst_n = 1'b0;
    #1;
    check_outputs("in_reset", 0, 0, '0, 0, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic         le, ue, ut, fl;
    logic [W-1:0] lp, up, pn, im;

    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset", 0, 0, '0, 0, '0);
    rst_n = 1'b1;

    fill_table();
    foreach (vecs[i]) begin
      drive(vecs[i].le, vecs[i].lp, vecs[i].ue, vecs[i].up, vecs[i].pn, vecs[i].im,
            vecs[i].ut, vecs[i].fl);
      @(posedge clk); #1;
      check_outputs(vecs[i].name, vecs[i].e_pv, vecs[i].e_pt, vecs[i].e_ptgt,
                    vecs[i].e_tv, vecs[i].e_tout);
    end

    // Allocate, then pull reset between edges: outputs drop at once and the
    // freshly allocated entry must not survive.
    drive(1'b0, '0, 1'b1, 32'h300, 32'h304, 32'h8, 1'b1, 1'b0);
    @(posedge clk); #1;
    check_outputs("pre_rst_alloc", 0, 0, 32'h144, 1, 32'h324);
    drive(1'b1, 32'h300, 1'b0, '0, '0, '0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs("async_rst", 0, 0, '0, 0, '0);
    @(posedge clk); #1;
    check_outputs("rst_held", 0, 0, '0, 0, '0);
    rst_n = 1'b1;
    drive(1'b1, 32'h300, 1'b0, '0, '0, '0, 1'b0, 1'b0);
    @(posedge clk); #1;
    check_outputs("post_rst_miss", 1, 0, 32'h304, 0, '0);

    // Randomized traffic against the model.
    apply_reset();
    model_reset();
    for (int n = 0; n < 400; n++) begin
      le = 1'($urandom_range(0, 3) != 0);
      ue = 1'($urandom_range(0, 2) != 0);
      ut = 1'($urandom_range(0, 1));
      fl = 1'($urandom_range(0, 29) == 0);
      lp = rand_pc();
      up = ($urandom_range(0, 1) == 1) ? lp : rand_pc();
      pn = ($urandom_range(0, 7) == 0) ? W'($urandom) : up + 4;
      im = ($urandom_range(0, 3) == 0) ? W'($urandom)
                                       : W'(32'($signed(12'($urandom))));
      drive(le, lp, ue, up, pn, im, ut, fl);
      model_step(le, lp, ue, up, pn, im, ut, fl);
      @(posedge clk); #1;
      check_outputs($sformatf("rand%0d", n), m_pv, m_pt, m_ptgt, m_tv, m_tout);
    end

    idle();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
